// File: rtl/sha256_w_sched.sv
// SHA-256 message-schedule generator: 16-word sliding window producing W_0..W_63 in step with
// the round counter's ready. Optional round check enabled by SHA256_W_ROUND_CHECK_EN.
module sha256_w_sched (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [511:0] block,
  input  logic         ready,
  input  logic [5:0]   round_idx,
  output logic [31:0]  w,
  output logic         w_valid,
  output logic         busy,
  output logic         done,
  output logic         round_err
);

  typedef enum logic [1:0] {StIdle, StArmed, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] win_q [16];
  logic [31:0] win_d [16];
  logic [5:0]  t_q, t_d;
  logic [31:0] nw;
  logic        load_win;
  logic        advance;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  assign nw = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    t_d      = t_q;
    load_win = 1'b0;
    advance  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          load_win = 1'b1;
          state_d  = StArmed;
        end
      end
      StArmed: begin
        if (ready) begin
          advance = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        // Counter resets whenever ready drops, so a stalled schedule can never rejoin it.
        if (!ready) begin
          state_d = StIdle;
        end else if (t_q == 6'd63) begin
          state_d = StDone;
        end else begin
          advance = 1'b1;
        end
      end
      StDone: begin
        if (load) begin
          load_win = 1'b1;
          state_d  = StArmed;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (load_win) begin
      for (int i = 0; i < 16; i++) begin
        win_d[i] = block[511-32*i -: 32];
      end
      t_d = 6'd0;
    end else if (advance) begin
      for (int i = 0; i < 15; i++) begin
        win_d[i] = win_q[i+1];
      end
      win_d[15] = nw;
      t_d       = t_q + 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      t_q     <= 6'd0;
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= 32'd0;
      end
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      win_q   <= win_d;
    end
  end

  assign busy    = (state_q == StArmed) || (state_q == StRun);
  assign w_valid = busy;
  assign w       = busy ? win_q[0] : 32'd0;
  assign done    = (state_q == StDone);

`ifdef SHA256_W_ROUND_CHECK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (load_win) begin
      err_q <= 1'b0;
    end else if (w_valid && ready && (round_idx != t_q)) begin
      err_q <= 1'b1;
    end
  end

  assign round_err = err_q;
`else
  logic unused_round_idx;
  assign unused_round_idx = ^round_idx;
  assign round_err        = 1'b0;
`endif

endmodule

// File: doc/sha256_w_sched.md
# sha256_w_sched

SHA-256 message-schedule generator. It is the consumer side of the round counter: the same `ready` that advances the counter advances this block, and the block presents W_t for the current round. It loads one 512-bit padded block and streams W_0..W_63 through a 16-word sliding window, one word per advancing cycle, to the compression datapath.

## Interface
Parameters:
- none. Widths are fixed by SHA-256.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: reset, synchronous and active-low.
- `load` in 1: capture `block` when the block is in IDLE or DONE.
- `block` in 512: padded message block; `block[511:480]` is M_0 (big-endian word order).
- `ready` in 1: round-advance enable, shared with the round counter.
- `round_idx` in 6: round index from the round counter; used only by the round-check feature.
- `w` out 32: current W_t.
- `w_valid` out 1: `w` is meaningful (ARMED or RUN).
- `busy` out 1: the block is in ARMED or RUN.
- `done` out 1: one-cycle pulse after W_63 is consumed.
- `round_err` out 1: round-mismatch flag (see Configuration).

## Operation
- Storage: 16 x 32-bit window `win[0..15]`, 6-bit internal round `t`, 2-bit state.
- States: IDLE, ARMED, RUN, DONE.
- `w = win[0]` in ARMED and RUN; 0 otherwise.
- Next word: `nw = s1(win[14]) + win[9] + s0(win[1]) + win[0]` mod 2^32.
  - s0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - s1(x) = ROTR17 ^ ROTR19 ^ SHR10.
- Advance: `win[i] <= win[i+1]` for i = 0..14, `win[15] <= nw`, `t <= t + 1`.
- IDLE:
  - `load` = 1: `win[i] <= block[511-32i -: 32]`, `t <= 0`, go to ARMED.
  - Otherwise stay in IDLE.
- ARMED:
  - `ready` = 0: hold, waiting for the counter to start.
  - `ready` = 1: W_0 is consumed this cycle; advance and go to RUN.
- RUN:
  - `ready` = 1 and `t` < 63: advance.
  - `ready` = 1 and `t` = 63: W_63 is consumed; go to DONE with no advance.
  - `ready` = 0: abort to IDLE. The counter returns to 0 when `ready` is low, so the schedule cannot resume in step. Window contents become don't-care.
- DONE:
  - `done` = 1 for this cycle only.
  - `load` = 1: go to ARMED with the new block.
  - Otherwise go to IDLE.
- `load` in ARMED or RUN is ignored. There is no queueing.
- `t` never wraps: RUN exits at 63.

## Timing
- Reset (`reset_n` = 0 at a rising edge): state IDLE, `win` all 0, `t` = 0.
  - Outputs after reset: `w` = 0, `w_valid` = 0, `busy` = 0, `done` = 0, `round_err` = 0.
- Reset overrides every other input, including reset mid-RUN.
- `load` at edge k: `w_valid` = 1 and `w` = M_0 after edge k.
- While `ready` stays high, `w` shows W_t during the cycle in which `round_idx` = t. The alignment holds when `ready` rises in the same cycle that ARMED is first seen.
- 64 consecutive `ready` cycles take the block from ARMED to DONE. `done` is high in the cycle after the W_63 cycle.
- All outputs are registered-state derived. The `nw` adder path is combinational within one cycle: three 32-bit adds plus XOR logic.

## Configuration
- Macro: `SHA256_W_ROUND_CHECK_EN`.
- Defined:
  - `round_err` is a registered flag, set in the cycle after any cycle where `w_valid` = 1, `ready` = 1 and `round_idx` != `t`.
  - It is cleared by reset or by an accepted `load`.
- Undefined:
  - `round_err` is tied to 0 and `round_idx` is ignored.
  - No compare logic is synthesised.

## Test plan
- "abc" block: `block` = 0x61626380, then 0 x14 words, then 0x00000018; load, then hold `ready` high for 64 cycles.
  - Required: W_0 = 0x61626380, W_15 = 0x00000018, W_16 = 0x61626380, W_17 = 0x000F0000, W_63 = 0x12B1EDEB.
  - `done` pulses in the cycle after the W_63 cycle; the block then returns to IDLE.
- ARMED stall: after `load`, hold `ready` low 5 cycles -> `w` = W_0 is held and `busy` = 1. Then raise `ready` -> the sequence runs as above.
- Abort: drop `ready` at t = 20 -> next cycle state IDLE, `w_valid` = 0, `busy` = 0, no `done`. A re-load restarts at W_0.
- Back-to-back: assert `load` in the DONE cycle with a second block -> ARMED next cycle with `w` = new M_0. `load` asserted mid-RUN is ignored, and `w` is unchanged in the following cycle.
- Reset mid-RUN: `reset_n` = 0 at t = 40 -> all outputs 0 after the edge, and the block is in IDLE.
- Round check (`SHA256_W_ROUND_CHECK_EN` defined): force `round_idx` = 7 while `t` = 6 -> `round_err` = 1 next cycle and stays set until `load`. Undefined build -> `round_err` stays 0.
